bu2020_memsys: RTL and testbench
================================

Name: bu2020_memsys

Overview:
- Memory-side responder for the BU2020 core. It serves the core's data bus (address, bidirectional data, write mode) and its instruction fetch bus.
- It contains the data RAM and the instruction RAM.
- A byte-stream boot loader fills instruction RAM after reset. The core is held idle through `cpu_run` until the image is complete.
- Sits at top level between the core and the host loader link.

Parameters:
- AW, 12, address width of both RAMs (depth 2^AW words).
- DW, 16, word width.
- DMEM_INIT, "", hex file for `$readmemh` of data RAM; empty means no init.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- Memory_addressbus  in  AW  data address from core.
- Memory_databus  inout  DW  data bus; driven by this block only on reads.
- Memory_writemode  in  1  1 = core writes, 0 = core reads.
- Instruction_addressbus  in  AW  fetch address.
- Instruction_databus  out  DW  fetched word.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  loader byte accepted when valid&&ready.
- ld_byte  in  8  loader data, high byte of each word first.
- ld_last  in  1  marks final byte of image.
- cpu_run  out  1  1 = core may execute; gates core reset/clock enable at top.
- ld_done  out  1  sticky, image loaded.
- ld_error  out  1  sticky, overflow (or checksum fail with feature).

Behaviour:
- Reset values: `cpu_run`=0, `ld_done`=0, `ld_error`=0, `ld_ready`=0, state=WAIT_HI, load address=0, byte latch=0. `Instruction_databus`=0 while `cpu_run`=0. `Memory_databus`=Z. RAM contents are not cleared.
- State machine:
  - WAIT_HI: `ld_ready`=1. On handshake, latch byte as [15:8].
    - If `ld_last`, write {byte,8'h00} and go to FINISH.
    - Else go to WAIT_LO.
  - WAIT_LO: `ld_ready`=1. On handshake, write {hi,byte} to iram[addr] and increment addr.
    - If `ld_last`, go to FINISH.
    - Else go to WAIT_HI.
  - FINISH: one cycle with `ld_ready`=0. Set `ld_done`=1 and `cpu_run`=1, then go to RUN.
  - RUN: `ld_ready`=0 and loader input is ignored. Leave RUN only via reset.
- Loader writes: the instruction RAM write happens on the same posedge as the handshake that completes the word.
- Overflow: a completed word with addr = 2^AW-1 writes normally and sets a wrap flag. Any further completed word sets `ld_error`=1 and is discarded (no wrap-around overwrite). The stream continues to be accepted until `ld_last`.
- `cpu_run` is asserted even when `ld_error`=1; the host decides on error.
- Instruction port: combinational read, `Instruction_databus`=iram[Instruction_addressbus], valid only when `cpu_run`=1.
- Data port, write (`cpu_run`=1 and `Memory_writemode`=1): dram[Memory_addressbus] <= `Memory_databus` at posedge. The block does not drive the bus.
- Data port, read (`cpu_run`=1 and `Memory_writemode`=0): drive `Memory_databus` combinationally with dram[addr], zero-cycle latency. A read after a write to the same address in the next cycle returns the new value.
- `cpu_run`=0: data writes are ignored and the bus stays Z.
- Reset mid-load: return to WAIT_HI with addr=0 and all flags cleared. Words already written stay in RAM and are overwritten by the next load.
- Simultaneous `ld_valid`&&`ld_last` on the first byte gives a single-word image.

Optional Feature:
- BU2020_LOAD_CHECKSUM_EN defined:
  - The final two bytes of the stream are a 16-bit checksum word, not code, and are not written to RAM.
  - The block keeps a running 16-bit modulo sum of all code words.
  - At FINISH, a mismatch sets `ld_error`=1.
  - A stream with fewer than 2 words sets `ld_error`=1.
- Undefined: every word is code, and there is no checksum logic.

Decomposition:
- Package `bu2020_pkg`: AW/DW defaults, loader state enum (WAIT_HI, WAIT_LO, FINISH, RUN), checksum width constant.
- One sub-module `bu2020_boot_loader`: FSM, byte assembly, address counter, flags, and optional checksum. It outputs a write strobe, address, data and `cpu_run`.
- RAMs and the tri-state driver stay in the top.

Test Plan:
- Reset, then stream bytes 12 34 56 78 (last on 78) -> iram[0]=16'h1234, iram[1]=16'h5678; `ld_done`=1 and `cpu_run`=1 one cycle after the last handshake; `ld_error`=0.
- Odd image AB CD EF (last on EF) -> iram[1]=16'hEF00, `ld_done`=1.
- CPU write addr 12'h010 data 16'hBEEF, next cycle read same address -> bus shows 16'hBEEF; with `Memory_writemode`=1 the bus is never driven by the block.
- Before `cpu_run`: write attempt to 12'h020 followed by a post-load read -> old value; bus Z during the load.
- AW=2 build: stream 5 words -> first 4 words stored, `ld_error`=1, `cpu_run`=1. Deassert `rst_n` mid-second-word -> state WAIT_HI and flags 0 immediately, without waiting for a clock edge.
- With BU2020_LOAD_CHECKSUM_EN, stream 0001 0002 0003 plus checksum 0006 -> `ld_error`=0, 3 words stored. Checksum 0007 -> `ld_error`=1.

Source files
------------

// File: rtl/bu2020_pkg.sv
// BU2020 memory system shared definitions.
// Loader state encoding and default widths.
package bu2020_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;
  localparam int CSUM_W = 16;

  typedef enum logic [1:0] {
    WAIT_HI,
    WAIT_LO,
    FINISH,
    RUN
  } ld_state_e;

endpackage

// File: rtl/bu2020_boot_loader.sv
// BU2020 boot loader: assembles loader bytes into IRAM words.
// BU2020_LOAD_CHECKSUM_EN: trailing word is a checksum, not code.
module bu2020_boot_loader
  import bu2020_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          cpu_run,
  output logic          ld_done,
  output logic          ld_error,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  ld_state_e     state, state_nx;
  logic [7:0]    hi_q;
  logic [AW-1:0] addr_q;
  logic          wrap_q;
  logic          hs;
  logic          word_done;
  logic [15:0]   word;
  logic          commit;
  logic [15:0]   cword;
  logic          csum_bad;

  assign hs        = ld_valid && ld_ready;
  assign word_done = hs && (state == WAIT_LO || ld_last);
  assign word      = (state == WAIT_LO) ? {hi_q, ld_byte}
                                        : {ld_byte, 8'h00};

`ifdef BU2020_LOAD_CHECKSUM_EN
  // A word is only known to be code once a later word arrives,
  // so each completed word is held back one word.
  logic [CSUM_W-1:0] pend_q;
  logic [CSUM_W-1:0] sum_q;
  logic              pend_v;

  assign commit   = word_done && pend_v;
  assign cword    = pend_q;
  assign csum_bad = word_done && ld_last &&
                    (!pend_v || ((sum_q + pend_q) != word));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      pend_v <= 1'b0;
      sum_q  <= '0;
    end else if (word_done && !ld_last) begin
      pend_q <= word;
      pend_v <= 1'b1;
      if (pend_v) sum_q <= sum_q + pend_q;
    end
  end
`else
  assign commit   = word_done;
  assign cword    = word;
  assign csum_bad = 1'b0;
`endif

  assign wr_en   = commit && !wrap_q;
  assign wr_addr = addr_q;
  assign wr_data = DW'(cword);

  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_HI: if (hs) state_nx = ld_last ? FINISH : WAIT_LO;
      WAIT_LO: if (hs) state_nx = ld_last ? FINISH : WAIT_HI;
      FINISH:  state_nx = RUN;
      RUN:     state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_HI;
      ld_ready <= 1'b0;
      hi_q     <= 8'h00;
      addr_q   <= '0;
      wrap_q   <= 1'b0;
      cpu_run  <= 1'b0;
      ld_done  <= 1'b0;
      ld_error <= 1'b0;
    end else begin
      state    <= state_nx;
      ld_ready <= (state_nx == WAIT_HI) ||
                  (state_nx == WAIT_LO);
      if (hs && state == WAIT_HI) hi_q <= ld_byte;
      // top word sets wrap; later words are dropped, never wrapped
      if (wr_en) begin
        addr_q <= addr_q + 1'b1;
        if (&addr_q) wrap_q <= 1'b1;
      end
      if ((commit && wrap_q) || csum_bad) ld_error <= 1'b1;
      if (state == FINISH) begin
        ld_done <= 1'b1;
        cpu_run <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bu2020_memsys.sv
// BU2020 memory system: IRAM/DRAM, data bus and boot loader.
// BU2020_LOAD_CHECKSUM_EN enables the loader image checksum.
module bu2020_memsys
  import bu2020_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter     DMEM_INIT = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] Memory_addressbus,
  inout  wire  [DW-1:0] Memory_databus,
  input  logic          Memory_writemode,
  input  logic [AW-1:0] Instruction_addressbus,
  output logic [DW-1:0] Instruction_databus,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  output logic          cpu_run,
  output logic          ld_done,
  output logic          ld_error
);

  logic [DW-1:0] iram [2**AW];
  logic [DW-1:0] dram [2**AW];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  bu2020_boot_loader #(
    .AW(AW),
    .DW(DW)
  ) u_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .cpu_run  (cpu_run),
    .ld_done  (ld_done),
    .ld_error (ld_error),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk) begin
    if (wr_en) iram[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (cpu_run && Memory_writemode)
      dram[Memory_addressbus] <= Memory_databus;
  end

  assign Instruction_databus =
    cpu_run ? iram[Instruction_addressbus] : '0;

  assign Memory_databus =
    (cpu_run && !Memory_writemode) ? dram[Memory_addressbus]
                                   : 'z;

endmodule

// File: tb/tb_bu2020_memsys.sv
// BU2020 memory system bench: image loads, data port, overflow.
// Main instance AW=12, second instance AW=2 for overflow.
module tb_bu2020_memsys;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n_s, sel;
  logic        vld, llast;
  logic [7:0]  lbyte;
  logic [11:0] maddr, iaddr;
  logic        wm, drv_oe;
  logic [15:0] drv_val;
  wire  [15:0] dbus_a, dbus_b;
  logic [15:0] idata_a, idata_b;
  logic        rdy_a, rdy_b, run_a, run_b;
  logic        done_a, done_b, err_a, err_b;
  wire  [15:0] dbus, idata;
  wire         rdy, run, done, err;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] dram_m [4096];
  bit          dram_k [4096];

  assign dbus_a = (drv_oe && !sel) ? drv_val : 'z;
  assign dbus_b = (drv_oe && sel) ? drv_val : 'z;
  assign dbus   = sel ? dbus_b : dbus_a;
  assign idata  = sel ? idata_b : idata_a;
  assign rdy    = sel ? rdy_b : rdy_a;
  assign run    = sel ? run_b : run_a;
  assign done   = sel ? done_b : done_a;
  assign err    = sel ? err_b : err_a;

  bu2020_memsys #(.AW(12), .DW(16)) u_dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .Memory_addressbus      (maddr),
    .Memory_databus         (dbus_a),
    .Memory_writemode       (wm && !sel),
    .Instruction_addressbus (iaddr),
    .Instruction_databus    (idata_a),
    .ld_valid               (vld && !sel),
    .ld_ready               (rdy_a),
    .ld_byte                (lbyte),
    .ld_last                (llast),
    .cpu_run                (run_a),
    .ld_done                (done_a),
    .ld_error               (err_a)
  );

  bu2020_memsys #(.AW(2), .DW(16)) u_small (
    .clk                    (clk),
    .rst_n                  (rst_n_s),
    .Memory_addressbus      (maddr[1:0]),
    .Memory_databus         (dbus_b),
    .Memory_writemode       (wm && sel),
    .Instruction_addressbus (iaddr[1:0]),
    .Instruction_databus    (idata_b),
    .ld_valid               (vld && sel),
    .ld_ready               (rdy_b),
    .ld_byte                (lbyte),
    .ld_last                (llast),
    .cpu_run                (run_b),
    .ld_done                (done_b),
    .ld_error               (err_b)
  );

  // Reference: pair bytes high-first, pad odd tail, cap at depth.
  function automatic void model(input logic [7:0] b[$],
                                input int aw,
                                output logic [15:0] code[$],
                                output bit e);
    logic [15:0] w[$];
    logic [15:0] sum;
    int depth;
    depth = 1 << aw;
    w = {};
    for (int i = 0; i < b.size(); i += 2) begin
      if (i + 1 < b.size()) w.push_back({b[i], b[i+1]});
      else w.push_back({b[i], 8'h00});
    end
    e = 1'b0;
    code = w;
`ifdef BU2020_LOAD_CHECKSUM_EN
    if (w.size() < 2) begin
      e = 1'b1;
      code = {};
    end else begin
      void'(code.pop_back());
      sum = 16'h0000;
      foreach (code[i]) sum += code[i];
      if (sum != w[w.size()-1]) e = 1'b1;
    end
`else
    sum = 16'h0000;
`endif
    if (code.size() > depth) begin
      e = 1'b1;
      code = code[0:depth-1];
    end
  endfunction

  task automatic send_stream(input logic [7:0] b[$], input int gap,
                             input bit mark_last);
    bit h;
    int budget;
    foreach (b[i]) begin
      vld   = 1'b1;
      lbyte = b[i];
      llast = mark_last && (i == b.size() - 1);
      budget = 0;
      forever begin
        @(negedge clk);
        h = rdy;
        @(posedge clk);
        if (h) break;
        budget++;
        if (budget > 50) begin
          vectors++;
          miscompares++;
          $display("FAIL handshake_timeout byte %0d ready=%b want 1",
                   i, rdy);
          break;
        end
      end
      #1;
      vld   = 1'b0;
      llast = 1'b0;
      if (i < b.size() - 1) begin
        repeat ($urandom_range(0, gap)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    if (sel) rst_n_s = 1'b0;
    else rst_n = 1'b0;
    @(posedge clk); #1;
    if (sel) rst_n_s = 1'b1;
    else rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
    maddr   = a;
    wm      = 1'b1;
    drv_oe  = 1'b1;
    drv_val = d;
    @(posedge clk); #1;
    wm     = 1'b0;
    drv_oe = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    iaddr = 12'h000;
    #2;
    vectors += 5;
    if (run !== 1'b0) begin miscompares++;
      $display("FAIL reset_run got %b want 0", run); end
    if (done !== 1'b0) begin miscompares++;
      $display("FAIL reset_done got %b want 0", done); end
    if (err !== 1'b0) begin miscompares++;
      $display("FAIL reset_err got %b want 0", err); end
    if (rdy !== 1'b0) begin miscompares++;
      $display("FAIL reset_rdy got %b want 0", rdy); end
    if (idata !== 16'h0000) begin miscompares++;
      $display("FAIL reset_idata got %h want 0000", idata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (rdy !== 1'b1) begin miscompares++;
      $display("FAIL rdy_after_reset got %b want 1", rdy); end
  endtask

  task automatic test_basic_load();
    logic [7:0]  b[$];
    logic [15:0] exp[$];
    bit e;
    b = {8'h12, 8'h34, 8'h56, 8'h78};
    model(b, 12, exp, e);
    send_stream(b, 0, 1'b1);
    vectors += 3;
    if (run !== 1'b0) begin miscompares++;
      $display("FAIL basic_run_early got %b want 0", run); end
    if (done !== 1'b0) begin miscompares++;
      $display("FAIL basic_done_early got %b want 0", done); end
    if (rdy !== 1'b0) begin miscompares++;
      $display("FAIL basic_rdy_finish got %b want 0", rdy); end
    @(posedge clk); #1;
    vectors += 3;
    if (done !== 1'b1) begin miscompares++;
      $display("FAIL basic_done got %b want 1", done); end
    if (run !== 1'b1) begin miscompares++;
      $display("FAIL basic_run got %b want 1", run); end
    if (err !== e) begin miscompares++;
      $display("FAIL basic_err got %b want %b", err, e); end
    foreach (exp[i]) begin
      iaddr = 12'(i); #1;
      vectors++;
      if (idata !== exp[i]) begin miscompares++;
        $display("FAIL basic_iram[%0d] got %h want %h",
                 i, idata, exp[i]); end
    end
  endtask

  task automatic test_odd_image();
    logic [7:0]  b[$];
    logic [15:0] exp[$];
    bit e;
    do_reset();
    b = {8'hAB, 8'hCD, 8'hEF};
    model(b, 12, exp, e);
    send_stream(b, 1, 1'b1);
    @(posedge clk); #1;
    vectors += 2;
    if (done !== 1'b1) begin miscompares++;
      $display("FAIL odd_done got %b want 1", done); end
    if (err !== e) begin miscompares++;
      $display("FAIL odd_err got %b want %b", err, e); end
    foreach (exp[i]) begin
      iaddr = 12'(i); #1;
      vectors++;
      if (idata !== exp[i]) begin miscompares++;
        $display("FAIL odd_iram[%0d] got %h want %h",
                 i, idata, exp[i]); end
    end
  endtask

  task automatic test_random_loads();
    logic [7:0]  b[$];
    logic [15:0] exp[$];
    bit e;
    int len;
    for (int n = 0; n < 4; n++) begin
      len = $urandom_range(1, 40);
      b = {};
      repeat (len) b.push_back(8'($urandom));
      model(b, 12, exp, e);
      do_reset();
      send_stream(b, 3, 1'b1);
      vectors++;
      if (run !== 1'b0) begin miscompares++;
        $display("FAIL rand_run_early load %0d got %b want 0",
                 n, run); end
      @(posedge clk); #1;
      vectors += 3;
      if (done !== 1'b1) begin miscompares++;
        $display("FAIL rand_done load %0d got %b want 1", n, done); end
      if (run !== 1'b1) begin miscompares++;
        $display("FAIL rand_run load %0d got %b want 1", n, run); end
      if (err !== e) begin miscompares++;
        $display("FAIL rand_err load %0d got %b want %b", n, err, e); end
      foreach (exp[i]) begin
        iaddr = 12'(i); #1;
        vectors++;
        if (idata !== exp[i]) begin miscompares++;
          $display("FAIL rand_iram[%0d] load %0d got %h want %h",
                   i, n, idata, exp[i]); end
      end
    end
  endtask

  task automatic test_data_port();
    logic [11:0] a;
    logic [15:0] d;
    sel = 1'b0;
    maddr   = 12'h010;
    wm      = 1'b1;
    drv_oe  = 1'b1;
    drv_val = 16'hBEEF;
    #1;
    vectors++;
    if (dbus !== 16'hBEEF) begin miscompares++;
      $display("FAIL wr_bus_free got %h want beef", dbus); end
    @(posedge clk); #1;
    wm = 1'b0;
    drv_oe = 1'b0;
    #1;
    vectors++;
    if (dbus !== 16'hBEEF) begin miscompares++;
      $display("FAIL raw_read got %h want beef", dbus); end
    dram_m[12'h010] = 16'hBEEF;
    dram_k[12'h010] = 1'b1;
    cpu_write(12'h020, 16'h1111);
    dram_m[12'h020] = 16'h1111;
    dram_k[12'h020] = 1'b1;
    repeat (40) begin
      a = 12'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1 || !dram_k[a]) begin
        d = 16'($urandom);
        cpu_write(a, d);
        dram_m[a] = d;
        dram_k[a] = 1'b1;
      end else begin
        maddr = a;
        wm = 1'b0;
        #1;
        vectors++;
        if (dbus !== dram_m[a]) begin miscompares++;
          $display("FAIL dram_read[%h] got %h want %h",
                   a, dbus, dram_m[a]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_write_before_run();
    logic [7:0]  b[$];
    logic [15:0] exp[$];
    bit e;
    do_reset();
    cpu_write(12'h020, 16'h2222);
    maddr   = 12'h020;
    wm      = 1'b0;
    drv_oe  = 1'b1;
    drv_val = 16'hA5A5;
    #1;
    vectors++;
    if (dbus !== 16'hA5A5) begin miscompares++;
      $display("FAIL idle_bus got %h want a5a5", dbus); end
    drv_oe = 1'b0;
    iaddr = 12'h000;
    #1;
    vectors++;
    if (idata !== 16'h0000) begin miscompares++;
      $display("FAIL ifetch_gated got %h want 0000", idata); end
    @(posedge clk); #1;
    b = {};
    repeat (4) b.push_back(8'($urandom));
    model(b, 12, exp, e);
    send_stream(b, 2, 1'b1);
    @(posedge clk); #1;
    maddr = 12'h020;
    #1;
    vectors += 2;
    if (run !== 1'b1) begin miscompares++;
      $display("FAIL wbr_run got %b want 1", run); end
    if (dbus !== dram_m[12'h020]) begin miscompares++;
      $display("FAIL wbr_old_value got %h want %h",
               dbus, dram_m[12'h020]); end
  endtask

  task automatic test_overflow();
    logic [7:0]  b[$];
    logic [15:0] exp[$];
    bit e;
    sel = 1'b1;
    do_reset();
    b = {};
    repeat (10) b.push_back(8'($urandom));
    model(b, 2, exp, e);
    send_stream(b, 2, 1'b1);
    @(posedge clk); #1;
    vectors += 3;
    if (err !== e) begin miscompares++;
      $display("FAIL ovf_err got %b want %b", err, e); end
    if (run !== 1'b1) begin miscompares++;
      $display("FAIL ovf_run got %b want 1", run); end
    if (done !== 1'b1) begin miscompares++;
      $display("FAIL ovf_done got %b want 1", done); end
    foreach (exp[i]) begin
      iaddr = 12'(i); #1;
      vectors++;
      if (idata !== exp[i]) begin miscompares++;
        $display("FAIL ovf_iram[%0d] got %h want %h",
                 i, idata, exp[i]); end
    end
    cpu_write(12'h001, 16'h5A3C);
    maddr = 12'h001;
    #1;
    vectors++;
    if (dbus !== 16'h5A3C) begin miscompares++;
      $display("FAIL small_dram got %h want 5a3c", dbus); end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0]  b[$];
    logic [15:0] exp[$];
    bit e;
    sel = 1'b1;
    @(posedge clk); #3;
    rst_n_s = 1'b0;
    #1;
    vectors += 3;
    if (run !== 1'b0) begin miscompares++;
      $display("FAIL async_run got %b want 0", run); end
    if (done !== 1'b0) begin miscompares++;
      $display("FAIL async_done got %b want 0", done); end
    if (err !== 1'b0) begin miscompares++;
      $display("FAIL async_err got %b want 0", err); end
    @(posedge clk); #1;
    rst_n_s = 1'b1;
    @(posedge clk); #1;
    b = {8'h11, 8'h22, 8'h33};
    send_stream(b, 0, 1'b0);
    vectors++;
    if (rdy !== 1'b1) begin miscompares++;
      $display("FAIL mid_rdy got %b want 1", rdy); end
    #1;
    rst_n_s = 1'b0;
    #1;
    vectors++;
    if (rdy !== 1'b0) begin miscompares++;
      $display("FAIL mid_async_rdy got %b want 0", rdy); end
    @(posedge clk); #1;
    rst_n_s = 1'b1;
    @(posedge clk); #1;
    b = {};
    repeat (4) b.push_back(8'($urandom));
    model(b, 2, exp, e);
    send_stream(b, 1, 1'b1);
    @(posedge clk); #1;
    vectors += 2;
    if (done !== 1'b1) begin miscompares++;
      $display("FAIL reload_done got %b want 1", done); end
    if (err !== e) begin miscompares++;
      $display("FAIL reload_err got %b want %b", err, e); end
    foreach (exp[i]) begin
      iaddr = 12'(i); #1;
      vectors++;
      if (idata !== exp[i]) begin miscompares++;
        $display("FAIL reload_iram[%0d] got %h want %h",
                 i, idata, exp[i]); end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_n_s = 1'b0;
    sel     = 1'b0;
    vld     = 1'b0;
    llast   = 1'b0;
    lbyte   = 8'h00;
    maddr   = 12'h000;
    iaddr   = 12'h000;
    wm      = 1'b0;
    drv_oe  = 1'b0;
    drv_val = 16'h0000;
    test_reset();
    test_basic_load();
    test_odd_image();
    test_random_loads();
    test_data_port();
    test_write_before_run();
    test_overflow();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
